// File: rtl/mux_sel_pkg.sv
// Shared constants and lane-extract helper for the mux_sel_pipe block.
// Lane width is limited to MAX_LANE_W and the flattened bus to MAX_BUS_W bits.
package mux_sel_pkg;

    localparam int DEFAULT_WIDTH  = 32;
    localparam int DEFAULT_NUM_IN = 4;
    localparam int MAX_NUM_IN     = 16;
    localparam int MAX_LANE_W     = 256;
    localparam int MAX_BUS_W      = MAX_NUM_IN * MAX_LANE_W;

    // Returns lane idx (width bits, zero-extended) of a zero-padded flattened bus.
    function automatic logic [MAX_LANE_W-1:0] lane_extract(
        input int unsigned          idx,
        input int unsigned          width,
        input logic [MAX_BUS_W-1:0] bus
    );
        logic [MAX_BUS_W-1:0]  shifted;
        logic [MAX_LANE_W-1:0] mask;
        shifted = bus >> (idx * width);
        mask    = ~({MAX_LANE_W{1'b1}} << width);
        return shifted[MAX_LANE_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/mux_sel_reg.sv
// One valid+data register stage with synchronous reset, clear and load.
// Clear has priority over load; data is kept on clear.
module mux_sel_reg
    import mux_sel_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= d;
        end
    end

endmodule

// File: rtl/mux_sel_pipe.sv
// Registered lane selector with valid/ready handshake, flush and sticky select error.
// Define MUX_SEL_PIPE_SKID_EN to add a one-entry skid register and a registered in_ready.
module mux_sel_pipe
    import mux_sel_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int NUM_IN = DEFAULT_NUM_IN,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    sel_err
);

    localparam logic [SEL_W:0] NUM_IN_W = (SEL_W + 1)'(NUM_IN);

    logic             sel_in_range;
    logic [WIDTH-1:0] sel_data;
    logic             accept;
    logic             xfer;
    logic             out_load;
    logic             out_clear;
    logic [WIDTH-1:0] out_d;

    assign sel_in_range = {1'b0, in_sel} < NUM_IN_W;
    assign sel_data     = sel_in_range
                        ? WIDTH'(lane_extract(32'(in_sel), WIDTH, MAX_BUS_W'(in_data)))
                        : '0;
    assign accept       = in_valid && in_ready && !flush;
    assign xfer         = out_valid && out_ready;

`ifdef MUX_SEL_PIPE_SKID_EN
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             skid_load;
    logic             skid_clear;

    // skid_valid is a flop, so in_ready carries no combinational path from out_ready.
    assign in_ready = !skid_valid;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        out_load   = 1'b0;
        out_clear  = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        out_d      = sel_data;
        if (flush) begin
            out_clear  = 1'b1;
            skid_clear = 1'b1;
        end else if (skid_valid) begin
            if (xfer) begin
                out_load   = 1'b1;
                out_d      = skid_data;
                skid_clear = 1'b1;
            end
        end else if (accept) begin
            if (!out_valid || out_ready) begin
                out_load = 1'b1;
            end else begin
                skid_load = 1'b1;
            end
        end else if (xfer) begin
            out_clear = 1'b1;
        end
    end

    mux_sel_reg #(.WIDTH(WIDTH)) u_skid_reg (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (sel_data),
        .valid (skid_valid),
        .data  (skid_data)
    );
`else
    assign in_ready = !out_valid || out_ready;

    always_comb begin
        out_load  = accept;
        out_clear = flush || (xfer && !accept);
        out_d     = sel_data;
    end
`endif

    mux_sel_reg #(.WIDTH(WIDTH)) u_out_reg (
        .clk   (clk),
        .rst   (rst),
        .load  (out_load),
        .clear (out_clear),
        .d     (out_d),
        .valid (out_valid),
        .data  (out_data)
    );

    // Sticky until reset; flush deliberately leaves it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err <= 1'b0;
        end else if (accept && !sel_in_range) begin
            sel_err <= 1'b1;
        end
    end

endmodule

// File: doc/mux_sel_pipe.md
MUX_SEL_PIPE -- requirements
Module: mux_sel_pipe

Interface
REQ-001 Parameter WIDTH, default 32: data width of every input and output lane.
REQ-002 Parameter NUM_IN, default 4: number of input lanes; legal range 2..16.
REQ-003 Parameter SEL_W, default $clog2(NUM_IN): select width, derived and not overridden.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  upstream offers a select/data set this cycle.
REQ-007 in_ready  output  1  block accepts the offer this cycle.
REQ-008 in_data  input  NUM_IN*WIDTH  flattened lanes; lane k occupies bits [k*WIDTH +: WIDTH].
REQ-009 in_sel  input  SEL_W  lane index to forward.
REQ-010 flush  input  1  discards all held items (pipeline kill).
REQ-011 out_valid  output  1  out_data holds a selected item.
REQ-012 out_ready  input  1  downstream consumes the item this cycle.
REQ-013 out_data  output  WIDTH  selected lane, registered.
REQ-014 sel_err  output  1  sticky flag: an accepted in_sel was >= NUM_IN.

Function
REQ-015 Accept occurs when in_valid && in_ready && !flush; a transfer occurs when out_valid && out_ready.
REQ-016 On accept, the block SHALL capture lane in_sel, or all-zero data if in_sel >= NUM_IN, and set sel_err.
REQ-017 Latency SHALL be exactly 1 cycle from accept to out_valid when the output stage is empty.
REQ-018 out_data SHALL remain stable while out_valid && !out_ready.
REQ-019 Output state: EMPTY (out_valid=0) -> FULL on accept; FULL -> EMPTY on transfer with no accept; FULL -> FULL on transfer plus accept, with new data loaded.
REQ-020 flush SHALL clear out_valid (and the skid entry, if present) at the next edge, regardless of in_valid or out_ready; sel_err is not cleared by flush.
REQ-021 A simultaneous accept and flush SHALL drop the accepted item.
REQ-022 No item SHALL be duplicated or lost, except through flush.

Reset
REQ-023 While rst is high at an edge: out_valid=0, out_data=0, sel_err=0, skid entry empty; rst overrides flush and accept.
REQ-024 In the cycle following reset release, in_ready SHALL be 1.

Configuration
REQ-025 Macro MUX_SEL_PIPE_SKID_EN defined: a one-entry skid register SHALL be compiled in.
- in_ready SHALL be registered and equal to !skid_valid.
- An accept while FULL && !out_ready SHALL fill the skid register.
- A transfer while the skid is full SHALL move the skid entry to the output stage; throughput is 1 item per cycle.
REQ-026 Macro undefined: no skid register; in_ready SHALL be the combinational term !out_valid || out_ready.

Structure
REQ-027 A shared package mux_sel_pkg SHALL hold the default WIDTH and NUM_IN constants and the lane-extract function (index, flattened bus -> WIDTH slice).
REQ-028 One sub-module, mux_sel_reg, SHALL implement one valid+data register stage with load/clear; it is instantiated once for the output stage and once more for the skid entry when MUX_SEL_PIPE_SKID_EN is defined.

Verification
REQ-029 The bench SHALL cover each of the following directed scenarios:
- Basic latency: rst 2 cycles, then WIDTH=32/NUM_IN=4, lanes {0x11,0x22,0x33,0x44}, in_sel=2, out_ready=1 -> out_valid=1 with out_data=0x33 one cycle after accept.
- Backpressure: out_ready=0, 3 consecutive offers A,B,C -> out_data holds A; with SKID_EN, in_ready drops after B; without SKID_EN, in_ready drops after A; release -> A,B,C in order, nothing lost.
- Out-of-range select: NUM_IN=3, in_sel=3 -> out_data=0, sel_err=1 and held through a later legal item; rst -> sel_err=0.
- Flush: output stage and skid both full, then flush=1 with in_valid=1 -> next cycle out_valid=0 and the offered item is absent downstream.
- Reset mid-stream: rst during a held item with out_ready=0 -> out_valid=0 and out_data=0 next cycle, in_ready=1.
- Throughput: SKID_EN, out_ready=1, 100 back-to-back items -> 100 transfers in 101 cycles, data matches the selected lanes.
